// File: rtl/passthrough_queue.sv
// ---------------------------------------------------------------------------
// passthrough_queue
//
// Ready/valid FIFO stage with configurable payload width and depth. When
// FLOW=1 an empty queue forwards the producer straight to the consumer in
// the same cycle. Otherwise data always spends at least one cycle in
// storage. A synchronous flush empties the queue, and the current
// occupancy is reported on io_count.
//
// Parameters
//   WIDTH  payload width in bits (>=1)
//   DEPTH  number of storage entries (>=1, any value, not only powers of two)
//   FLOW   1 = same-cycle flow-through when empty, 0 = registered only
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous active-high reset (clears pointers/count)
//   io_enq_valid  producer has data
//   io_enq_ready  queue accepts data this cycle
//   io_enq_bits   producer payload
//   io_deq_valid  queue presents data
//   io_deq_ready  consumer takes data this cycle
//   io_deq_bits   head payload (undefined while io_deq_valid=0)
//   io_flush      synchronous clear of all contents, priority over transfers
//   io_count      number of entries currently held in storage
// ---------------------------------------------------------------------------
module passthrough_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int FLOW  = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_enq_valid,
  output logic                       io_enq_ready,
  input  logic [WIDTH-1:0]           io_enq_bits,
  output logic                       io_deq_valid,
  input  logic                       io_deq_ready,
  output logic [WIDTH-1:0]           io_deq_bits,
  input  logic                       io_flush,
  output logic [$clog2(DEPTH+1)-1:0] io_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  // A single-entry queue still needs a one-bit pointer to index storage.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;

  logic empty;
  logic flowThrough;
  logic enqFire;
  logic deqFire;
  logic passThru;
  logic doWrite;
  logic doRead;

  // Pointers wrap by explicit compare so that non-power-of-two depths
  // cycle through exactly DEPTH slots.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    nextPtr = (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty       = (count_q == '0);
  assign flowThrough = (FLOW != 0) && empty;

  // Flush gates both handshakes so nothing can transfer on a flush edge.
  assign io_enq_ready = !full_q && !io_flush;
  assign io_deq_valid = flowThrough ? (io_enq_valid && !io_flush)
                                    : (!empty && !io_flush);
  assign io_deq_bits  = flowThrough ? io_enq_bits : mem[rdPtr_q];
  assign io_count     = count_q;

  assign enqFire = io_enq_valid && io_enq_ready;
  assign deqFire = io_deq_valid && io_deq_ready;

  // In flow-through with both sides firing, the word goes straight across
  // and storage is left untouched. A dequeue while empty can only happen
  // in that case, so reads are always backed by a stored entry.
  assign passThru = flowThrough && enqFire && deqFire;
  assign doWrite  = enqFire && !passThru;
  assign doRead   = deqFire && !passThru;

  // Next-state for pointers, occupancy and the full flag.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (io_flush) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (doWrite) wrPtr_d = nextPtr(wrPtr_q);
      if (doRead)  rdPtr_d = nextPtr(rdPtr_q);
      case ({doWrite, doRead})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    full_d = (count_d == FULL_CNT);
  end

  // Control state, cleared immediately by the asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  // Payload storage is deliberately left out of reset; an empty queue
  // never exposes it.
  always_ff @(posedge clock) begin
    if (doWrite) mem[wrPtr_q] <= io_enq_bits;
  end

endmodule

// File: tb/tb_passthrough_queue.sv
// ---------------------------------------------------------------------------
// tb_passthrough_queue
//
// Exercises three queue instances sharing one clock and reset:
//   A: WIDTH=8 DEPTH=4 FLOW=0  reset, fill/full/wrap, simultaneous, flush,
//                              asynchronous reset mid-stream
//   B: WIDTH=8 DEPTH=3 FLOW=0  non-power-of-two wrap under streaming
//   C: WIDTH=8 DEPTH=4 FLOW=1  same-cycle flow-through and stored path
// Expected words are queued as stimulus is issued, and a monitor per
// instance pops and compares whenever that instance completes a dequeue.
// ---------------------------------------------------------------------------
module tb_passthrough_queue;

  logic clock;
  logic reset;

  logic       aEnqValid, aEnqReady, aDeqValid, aDeqReady, aFlush;
  logic [7:0] aEnqBits, aDeqBits;
  logic [2:0] aCount;

  logic       bEnqValid, bEnqReady, bDeqValid, bDeqReady, bFlush;
  logic [7:0] bEnqBits, bDeqBits;
  logic [1:0] bCount;

  logic       cEnqValid, cEnqReady, cDeqValid, cDeqReady, cFlush;
  logic [7:0] cEnqBits, cDeqBits;
  logic [2:0] cCount;

  logic [7:0] qA[$];
  logic [7:0] qB[$];
  logic [7:0] qC[$];

  int checks = 0;
  int errors = 0;

  passthrough_queue #(.WIDTH(8), .DEPTH(4), .FLOW(0)) dutA (
    .clock(clock), .reset(reset),
    .io_enq_valid(aEnqValid), .io_enq_ready(aEnqReady), .io_enq_bits(aEnqBits),
    .io_deq_valid(aDeqValid), .io_deq_ready(aDeqReady), .io_deq_bits(aDeqBits),
    .io_flush(aFlush), .io_count(aCount)
  );

  passthrough_queue #(.WIDTH(8), .DEPTH(3), .FLOW(0)) dutB (
    .clock(clock), .reset(reset),
    .io_enq_valid(bEnqValid), .io_enq_ready(bEnqReady), .io_enq_bits(bEnqBits),
    .io_deq_valid(bDeqValid), .io_deq_ready(bDeqReady), .io_deq_bits(bDeqBits),
    .io_flush(bFlush), .io_count(bCount)
  );

  passthrough_queue #(.WIDTH(8), .DEPTH(4), .FLOW(1)) dutC (
    .clock(clock), .reset(reset),
    .io_enq_valid(cEnqValid), .io_enq_ready(cEnqReady), .io_enq_bits(cEnqBits),
    .io_deq_valid(cDeqValid), .io_deq_ready(cDeqReady), .io_deq_bits(cDeqBits),
    .io_flush(cFlush), .io_count(cCount)
  );

  // 10 ns clock period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against its expected value and tally it.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle's worth of inputs onto the selected instance.
  task automatic applyStimulus(input int dut, input logic v, input logic [7:0] d,
                               input logic r, input logic f);
    case (dut)
      0: begin aEnqValid = v; aEnqBits = d; aDeqReady = r; aFlush = f; end
      1: begin bEnqValid = v; bEnqBits = d; bDeqReady = r; bFlush = f; end
      default: begin cEnqValid = v; cEnqBits = d; cDeqReady = r; cFlush = f; end
    endcase
  endtask

  // Advance past the next rising edge, leaving inputs stable mid-cycle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitors sample in the middle of the cycle, before the edge on which
  // the observed handshake completes, and pop the oldest expected word.
  always @(negedge clock) begin
    if (!reset && aDeqValid && aDeqReady) begin
      if (qA.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL aUnexpected actual=%0h required=none", aDeqBits);
      end else begin
        checkOutput("aData", {24'd0, aDeqBits}, {24'd0, qA.pop_front()});
      end
    end
    if (aCount > 3'd4) checkOutput("aCountBound", {29'd0, aCount}, 32'd4);
  end

  always @(negedge clock) begin
    if (!reset && bDeqValid && bDeqReady) begin
      if (qB.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL bUnexpected actual=%0h required=none", bDeqBits);
      end else begin
        checkOutput("bData", {24'd0, bDeqBits}, {24'd0, qB.pop_front()});
      end
    end
    if (bCount > 2'd3) checkOutput("bCountBound", {30'd0, bCount}, 32'd3);
  end

  always @(negedge clock) begin
    if (!reset && cDeqValid && cDeqReady) begin
      if (qC.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL cUnexpected actual=%0h required=none", cDeqBits);
      end else begin
        checkOutput("cData", {24'd0, cDeqBits}, {24'd0, qC.pop_front()});
      end
    end
    if (cCount > 3'd4) checkOutput("cCountBound", {29'd0, cCount}, 32'd4);
  end

  // Directed sequence for all three instances.
  initial begin
    reset = 1'b1;
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(2, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    checkOutput("rstEnqReady", {31'd0, aEnqReady}, 32'd1);
    checkOutput("rstDeqValid", {31'd0, aDeqValid}, 32'd0);
    checkOutput("rstCount",    {29'd0, aCount},    32'd0);
    tick();
    reset = 1'b0;
    #1;

    // Single word: visible one cycle after it is written.
    applyStimulus(0, 1'b1, 8'hA5, 1'b0, 1'b0); qA.push_back(8'hA5);
    tick();
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("oneCount", {29'd0, aCount},    32'd1);
    checkOutput("oneValid", {31'd0, aDeqValid}, 32'd1);
    checkOutput("oneBits",  {24'd0, aDeqBits},  32'hA5);
    applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("oneDrained", {31'd0, aDeqValid}, 32'd0);

    // Fill to full, then show the fifth word is held off.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 1'b1, 8'(i), 1'b0, 1'b0); qA.push_back(8'(i));
      tick();
    end
    checkOutput("fullCount", {29'd0, aCount},    32'd4);
    checkOutput("fullReady", {31'd0, aEnqReady}, 32'd0);
    applyStimulus(0, 1'b1, 8'h05, 1'b0, 1'b0);
    tick();
    checkOutput("heldCount", {29'd0, aCount}, 32'd4);

    // Take two, add two more across the wrap point, then drain.
    applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0);
    tick(); tick();
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("halfCount", {29'd0, aCount}, 32'd2);
    for (int i = 5; i <= 6; i++) begin
      applyStimulus(0, 1'b1, 8'(i), 1'b0, 1'b0); qA.push_back(8'(i));
      tick();
    end
    checkOutput("wrapCount", {29'd0, aCount}, 32'd4);
    applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0);
    repeat (4) tick();
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("wrapEmptyCount", {29'd0, aCount},    32'd0);
    checkOutput("wrapEmptyValid", {31'd0, aDeqValid}, 32'd0);

    // Steady streaming with two entries resident.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1'b1, 8'h10 + 8'(i), 1'b0, 1'b0); qA.push_back(8'h10 + 8'(i));
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1'b1, 8'h20 + 8'(i), 1'b1, 1'b0); qA.push_back(8'h20 + 8'(i));
      tick();
      checkOutput("simCount", {29'd0, aCount}, 32'd2);
    end
    applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0);
    tick(); tick();
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("simDrained", {29'd0, aCount}, 32'd0);

    // Flush with both sides requesting: nothing may transfer.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
      tick();
    end
    checkOutput("preFlushCount", {29'd0, aCount}, 32'd3);
    applyStimulus(0, 1'b1, 8'h40, 1'b1, 1'b1);
    #1;
    checkOutput("flushEnqReady", {31'd0, aEnqReady}, 32'd0);
    checkOutput("flushDeqValid", {31'd0, aDeqValid}, 32'd0);
    tick();
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("postFlushCount", {29'd0, aCount},    32'd0);
    checkOutput("postFlushValid", {31'd0, aDeqValid}, 32'd0);
    applyStimulus(0, 1'b1, 8'h50, 1'b0, 1'b0); qA.push_back(8'h50);
    tick();
    applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset pulse between edges discards everything immediately.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("preRstCount", {29'd0, aCount}, 32'd3);
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncRstCount", {29'd0, aCount},    32'd0);
    checkOutput("asyncRstValid", {31'd0, aDeqValid}, 32'd0);
    reset = 1'b0;
    tick();
    applyStimulus(0, 1'b1, 8'h77, 1'b0, 1'b0); qA.push_back(8'h77);
    tick();
    applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("aDrained", qA.size(), 32'd0);

    // DEPTH=3: full at three, then stream across several wraps.
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1, 1'b1, 8'(i), 1'b0, 1'b0); qB.push_back(8'(i));
      tick();
    end
    checkOutput("bFullCount", {30'd0, bCount},    32'd3);
    checkOutput("bFullReady", {31'd0, bEnqReady}, 32'd0);
    applyStimulus(1, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1, 1'b1, 8'h80 + 8'(i), 1'b1, 1'b0); qB.push_back(8'h80 + 8'(i));
      tick();
      checkOutput("bSimCount", {30'd0, bCount}, 32'd2);
    end
    applyStimulus(1, 1'b0, 8'h00, 1'b1, 1'b0);
    tick(); tick();
    applyStimulus(1, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("bEmptyCount", {30'd0, bCount}, 32'd0);
    checkOutput("bDrained", qB.size(), 32'd0);

    // FLOW=1: empty queue passes the word across in the same cycle.
    applyStimulus(2, 1'b1, 8'h3C, 1'b1, 1'b0); qC.push_back(8'h3C);
    #1;
    checkOutput("cFlowValid", {31'd0, cDeqValid}, 32'd1);
    checkOutput("cFlowBits",  {24'd0, cDeqBits},  32'h3C);
    tick();
    applyStimulus(2, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("cFlowCount", {29'd0, cCount}, 32'd0);

    // FLOW=1 with the consumer stalled: the word is stored instead.
    applyStimulus(2, 1'b1, 8'h3C, 1'b0, 1'b0); qC.push_back(8'h3C);
    #1;
    checkOutput("cStallValid", {31'd0, cDeqValid}, 32'd1);
    tick();
    applyStimulus(2, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("cStoreCount", {29'd0, cCount},    32'd1);
    checkOutput("cStoreValid", {31'd0, cDeqValid}, 32'd1);
    checkOutput("cStoreBits",  {24'd0, cDeqBits},  32'h3C);
    applyStimulus(2, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    applyStimulus(2, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("cEmptyCount", {29'd0, cCount}, 32'd0);
    checkOutput("cDrained", qC.size(), 32'd0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
